oam_dma: RTL

- Sprite DMA engine, upstream of the PPU register interface.
- A CPU write to $4014 captures a page number and stalls the CPU. The engine then takes over the CPU memory bus and copies 256 bytes from $XX00–$XXFF into OAM through repeated writes to $2004.
- Sits between the CPU and the memory controller bus mux. While active_out=1, the top level gives the bus to the dma_* outputs and deasserts CPU ready.

---
 rtl/oam_dma.sv | 102 ++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to TRIGGER_ADDR starts a 256-byte page copy into OAM_PORT_ADDR, one read/write pair per byte.
// Latency: active_out rises one edge after the trigger; 513/514 cycles. No backpressure: everything advances only on cyc_en_in.
module oam_dma #(
   parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_PORT_ADDR = 16'h2004
) (
   input  logic        clk_in,
   input  logic        nrst_in,
   input  logic        cyc_en_in,
   input  logic [15:0] cpumc_a_in,
   input  logic        cpumc_r_nw_in,
   input  logic [7:0]  cpumc_d_in,
   input  logic [7:0]  mem_d_in,
   output logic        active_out,
   output logic [15:0] dma_a_out,
   output logic [7:0]  dma_d_out,
   output logic        dma_r_nw_out,
   output logic        done_out
);

   typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

   state_t     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;
   logic       parity_q;
   logic       done_q, done_d;

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         state_q  <= S_IDLE;
         page_q   <= 8'h00;
         idx_q    <= 8'h00;
         data_q   <= 8'h00;
         parity_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         parity_q <= parity_q ^ cyc_en_in;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      data_d  = data_q;
      done_d  = 1'b0;
      if (cyc_en_in) begin
         case (state_q)
            S_IDLE: begin
               if (!cpumc_r_nw_in && cpumc_a_in == TRIGGER_ADDR) begin
                  state_d = S_HALT;
                  page_d  = cpumc_d_in;
                  idx_d   = 8'h00;
               end
            end
            // An odd cycle at HALT needs one extra dummy cycle to line up reads.
            S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
               data_d  = mem_d_in;
               state_d = S_WRITE;
            end
            S_WRITE: begin
               idx_d = idx_q + 8'd1;
               if (idx_q == 8'hFF) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      active_out   = (state_q != S_IDLE);
      dma_a_out    = 16'h0000;
      dma_d_out    = 8'h00;
      dma_r_nw_out = 1'b1;
      case (state_q)
         S_READ:  dma_a_out = {page_q, idx_q};
         S_WRITE: begin
            dma_a_out    = OAM_PORT_ADDR;
            dma_d_out    = data_q;
            dma_r_nw_out = 1'b0;
         end
         default: ;
      endcase
   end

   assign done_out = done_q;

endmodule
